// File: rtl/ss_tr_queue.sv
// rtl/ss_tr_queue.sv - DEPTH-entry FIFO of temporaries loaded from one of N_SRC sources
module ss_tr_queue #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 5,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [N_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]       tr_src,
  input  logic                   tr_write,
  input  logic                   tr_read,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       tr,
  output logic                   tr_valid,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output logic                   err
);

  localparam int PTR_W = $clog2(DEPTH);
  // One extra bit so N_SRC == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] N_SRC_L = (SEL_W + 1)'(N_SRC);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic             w_full;
  logic             w_empty;
  logic             w_src_ok;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_bad_src;
  logic             w_overflow;
  logic             w_underflow;
  logic             w_err_set;
  logic [WIDTH-1:0] w_src_data;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign w_src_ok  = ({1'b0, tr_src} < N_SRC_L);
  assign w_push_ok = tr_write & w_src_ok & (~w_full | tr_read);
  assign w_pop_ok  = tr_read & ~w_empty;

  assign w_bad_src  = tr_write & ~w_src_ok;
  assign w_overflow = tr_write & w_src_ok & w_full & ~tr_read;
  // A read on an empty queue paired with an accepted push is the defined
  // push-only case, not an underflow.
  assign w_underflow = tr_read & w_empty & ~w_push_ok;
  assign w_err_set   = w_bad_src | w_overflow | w_underflow;

  always_comb begin
    w_src_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (tr_src == k[SEL_W-1:0]) begin
        w_src_data = src_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Storage is deliberately not reset; validity comes from the count.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_src_data;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign tr       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign tr_valid = ~w_empty;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign err      = r_err;

endmodule
